// File: rtl/trdb_branch_map_if.sv
// Branch map bus: retire/flush inputs from the trace core and the
// map/count/flag outputs consumed by trdb_priority and the emitter.
interface trdb_branch_map_if #(
  parameter int unsigned MAX_BRANCHES = 31,
  parameter int unsigned CNT_W        = $clog2(MAX_BRANCHES + 1)
);
  logic                    valid_i;
  logic                    branch_i;
  logic                    branch_taken_i;
  logic                    flush_i;
  logic [MAX_BRANCHES-1:0] map_o;
  logic [CNT_W-1:0]        branches_o;
  logic                    is_full_o;
  logic                    is_empty_o;
  logic                    overflow_o;

  modport master (
    output valid_i, branch_i, branch_taken_i, flush_i,
    input  map_o, branches_o, is_full_o, is_empty_o, overflow_o
  );

  modport slave (
    input  valid_i, branch_i, branch_taken_i, flush_i,
    output map_o, branches_o, is_full_o, is_empty_o, overflow_o
  );
endinterface

// File: rtl/trdb_branch_map.sv
// Accumulates retired conditional branch outcomes into a format-1 branch map.
// Bit value 1 means NOT taken; unused bits above the count stay 0.
module trdb_branch_map #(
  parameter int unsigned MAX_BRANCHES = 31,
  parameter int unsigned CNT_W        = $clog2(MAX_BRANCHES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  trdb_branch_map_if.slave  bus
);

  logic [MAX_BRANCHES-1:0] map_q, map_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    overflow_q, overflow_d;

  logic                    push;
  logic                    nt_bit;
  logic                    full;

  assign push   = bus.valid_i & bus.branch_i;
  assign nt_bit = ~bus.branch_taken_i;
  assign full   = (cnt_q == CNT_W'(MAX_BRANCHES));

  always_comb begin
    map_d      = map_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (bus.flush_i) begin
      // The flush consumes the pre-edge map; a same-cycle branch opens the fresh one.
      map_d = '0;
      cnt_d = '0;
      if (push) begin
        map_d = {{(MAX_BRANCHES-1){1'b0}}, nt_bit};
        cnt_d = CNT_W'(1);
      end
    end else if (push) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        map_d = map_q | ({{(MAX_BRANCHES-1){1'b0}}, nt_bit} << cnt_q);
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      map_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      map_q      <= map_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.map_o      = map_q;
  assign bus.branches_o = cnt_q;
  assign bus.is_full_o  = full;
  assign bus.is_empty_o = (cnt_q == '0);
  assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_trdb_branch_map.sv
// Directed, table-driven bench for trdb_branch_map with hand-written
// sequences for fill, overflow and filtering corner cases.
module tb_trdb_branch_map;

  localparam int unsigned MaxBr = 31;
  localparam int unsigned CntW  = 5;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  bit   started;

  trdb_branch_map_if #(.MAX_BRANCHES(MaxBr), .CNT_W(CntW)) bus ();

  trdb_branch_map #(.MAX_BRANCHES(MaxBr), .CNT_W(CntW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic       branch;
    logic       taken;
    logic       flush;
    logic [30:0] map;
    logic [4:0]  cnt;
    logic       ovf;
  } vec_t;

  vec_t vecs [14];

  // Apply inputs for one rising edge, then sample 1 time unit after it.
  task automatic step(input logic r, input logic v, input logic b, input logic t,
                      input logic f);
    rst                = r;
    bus.valid_i        = v;
    bus.branch_i       = b;
    bus.branch_taken_i = t;
    bus.flush_i        = f;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [30:0] emap, input logic [4:0] ecnt,
                       input logic eovf);
    logic efull;
    logic eempty;
    efull  = (ecnt == 5'd31);
    eempty = (ecnt == 5'd0);
    n_checks++;
    if (bus.map_o === emap && bus.branches_o === ecnt && bus.is_full_o === efull &&
        bus.is_empty_o === eempty && bus.overflow_o === eovf) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got map=%h cnt=%0d full=%b empty=%b ovf=%b, want map=%h cnt=%0d full=%b empty=%b ovf=%b",
               name, bus.map_o, bus.branches_o, bus.is_full_o, bus.is_empty_o, bus.overflow_o,
               emap, ecnt, efull, eempty, eovf);
    end
  endtask

  // Bits at or above the count must always read 0.
  always @(negedge clk) begin
    if (started) begin
      logic [31:0] mask;
      mask = (32'h1 << bus.branches_o) - 32'h1;
      n_checks++;
      if (({1'b0, bus.map_o} & ~mask) === 32'h0) begin
        n_pass++;
      end else begin
        $display("FAIL unused_bits: map=%h cnt=%0d, want bits >= cnt zero",
                 bus.map_o, bus.branches_o);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    started  = 1'b0;

    //          rst   vld   br    tkn   fl    map      cnt   ovf
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 31'h0, 5'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 31'h0, 5'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 31'h1, 5'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 31'h0, 5'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 31'h0, 5'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 31'h2, 5'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 31'h6, 5'd3, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 31'h6, 5'd4, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 31'h1, 5'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 31'h1, 5'd2, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 31'h5, 5'd3, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 31'h5, 5'd3, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 31'h5, 5'd3, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 31'h0, 5'd0, 1'b0};

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    started = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].branch, vecs[i].taken, vecs[i].flush);
      check($sformatf("vec%0d", i), vecs[i].map, vecs[i].cnt, vecs[i].ovf);
    end

    // Non-branch filtering from count 3 (taken, not-taken, taken -> map 0b010).
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("filter_pre", 31'h2, 5'd3, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("filter_nobranch", 31'h2, 5'd3, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("filter_novalid", 31'h2, 5'd3, 1'b0);

    // Flush alone from count 7.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_flush7", 31'h7F, 5'd7, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("flush7", 31'h0, 5'd0, 1'b0);

    // Push+flush from count 5 (all taken).
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("pre_pf5", 31'h0, 5'd5, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("push_flush5", 31'h1, 5'd1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Fill to capacity, then push+flush from full.
    for (int i = 0; i < 31; i++) begin
      logic [31:0] em;
      em = (32'h1 << (i + 1)) - 32'h1;
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check($sformatf("fill_a%0d", i), em[30:0], 5'(i + 1), 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("push_flush_full", 31'h0, 5'd1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Fill again and overflow.
    for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("full", 31'h7FFF_FFFF, 5'd31, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("overflow", 31'h7FFF_FFFF, 5'd31, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("overflow_hold", 31'h7FFF_FFFF, 5'd31, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("overflow_sticky", 31'h0, 5'd0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("overflow_push", 31'h1, 5'd1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_clears", 31'h0, 5'd0, 1'b0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
